// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback/commit unit.
package wb_commit_pkg;
    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [4:0]      r_t;

    localparam data_t NULL = '0;
    localparam r_t    ZERO = '0;

    typedef struct packed {
        r_t    rd;
        data_t data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers carry one extra wrap bit.
module wb_fifo
    import wb_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_entry_t   mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/wb_commit.sv
// Writeback/commit: ALU-first arbitration into one registered RF write port,
// plus a pending-write scoreboard for decode hazard stalls.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  alu_valid,
    input  r_t    alu_rd,
    input  data_t alu_data,
    input  logic  lsu_valid,
    output logic  lsu_ready,
    input  r_t    lsu_rd,
    input  data_t lsu_data,
    input  logic  issue_valid,
    input  r_t    issue_rd,
    input  r_t    rs1_addr,
    input  r_t    rs2_addr,
    output logic  rs1_busy,
    output logic  rs2_busy,
    output logic  rd_wren,
    output r_t    rd_addr,
    output data_t rd_data,
    output logic  idle
);
    wb_entry_t   fifo_head;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic        commit_v;
    r_t          commit_rd;
    data_t       commit_data;
    logic        rd_wren_q, rd_wren_d;
    r_t          rd_addr_q, rd_addr_d;
    data_t       rd_data_q, rd_data_d;
    logic [31:0] pending_q, pending_d;

    assign lsu_ready = !fifo_full;
    assign fifo_push = lsu_valid && !fifo_full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ('{rd: lsu_rd, data: lsu_data}),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        commit_v    = alu_valid || !fifo_empty;
        fifo_pop    = !alu_valid && !fifo_empty;
        commit_rd   = alu_valid ? alu_rd   : fifo_head.rd;
        commit_data = alu_valid ? alu_data : fifo_head.data;

        rd_wren_d = 1'b0;
        rd_addr_d = ZERO;
        rd_data_d = NULL;
        if (commit_v && commit_rd != ZERO) begin
            rd_wren_d = 1'b1;
            rd_addr_d = commit_rd;
            rd_data_d = commit_data;
        end

        // Set after clear so a newly issued writer keeps ownership.
        pending_d = pending_q;
        if (commit_v)    pending_d[commit_rd] = 1'b0;
        if (issue_valid) pending_d[issue_rd]  = 1'b1;
        pending_d[0] = 1'b0;
    end

    function automatic logic busy_of(input r_t rs);
        return (rs != ZERO) && pending_q[rs] &&
               !(commit_v && commit_rd == rs && !(issue_valid && issue_rd == rs));
    endfunction

    assign rs1_busy = busy_of(rs1_addr);
    assign rs2_busy = busy_of(rs2_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_wren_q <= 1'b0;
            rd_addr_q <= ZERO;
            rd_data_q <= NULL;
            pending_q <= '0;
        end else begin
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pending_q <= pending_d;
        end
    end

    assign rd_wren = rd_wren_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;
    assign idle    = fifo_empty && (pending_q == '0);
endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_commit;
    import wb_commit_pkg::*;

    localparam int DEPTH = 4;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    r_t    alu_rd = '0, lsu_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
    data_t alu_data = '0, lsu_data = '0;
    logic  lsu_ready, rs1_busy, rs2_busy, rd_wren, idle;
    r_t    rd_addr;
    data_t rd_data;

    wb_commit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd_wren(rd_wren), .rd_addr(rd_addr), .rd_data(rd_data), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    wren;
        r_t    addr;
        data_t data;
    } exp_t;

    exp_t      exp_q[$];
    wb_entry_t model_fifo[$];
    bit        model_pend[32];
    bit        model_known = 0;
    int        checks = 0;
    int        failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered write-port value.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_wren", 32'(rd_wren), 32'(e.wren));
                check("rd_addr", 32'(rd_addr), 32'(e.addr));
                check("rd_data", rd_data, e.data);
            end
        end
    end

    function automatic bit model_idle();
        bit any = 0;
        for (int i = 0; i < 32; i++) any |= model_pend[i];
        return (model_fifo.size() == 0) && !any;
    endfunction

    // One clock of stimulus: drive, check combinational outputs against the
    // model, queue the expected write, then advance the model by one edge.
    task automatic cyc(input bit rn, input bit av, input r_t ard, input data_t adat,
                       input bit lv, input r_t lrd, input data_t ldat,
                       input bit iv, input r_t ird, input r_t r1, input r_t r2);
        bit        cv;
        r_t        crd;
        data_t     cdat;
        int        occ;
        exp_t      e;
        @(posedge clk);
        #2;
        rst_n = rn; alu_valid = av; alu_rd = ard; alu_data = adat;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
        issue_valid = iv; issue_rd = ird; rs1_addr = r1; rs2_addr = r2;
        #1;
        occ  = model_fifo.size();
        cv   = av || (occ > 0);
        crd  = av ? ard : (occ > 0 ? model_fifo[0].rd : r_t'(0));
        cdat = av ? adat : (occ > 0 ? model_fifo[0].data : data_t'(0));
        if (!rn) begin
            e = '{0, '0, '0};
            exp_q.push_back(e);
            model_fifo.delete();
            for (int i = 0; i < 32; i++) model_pend[i] = 0;
            model_known = 1;
        end else if (model_known) begin
            check("lsu_ready", 32'(lsu_ready), 32'(occ < DEPTH));
            check("idle", 32'(idle), 32'(model_idle()));
            check("rs1_busy", 32'(rs1_busy),
                  32'(r1 != 0 && model_pend[r1] && !(cv && crd == r1 && !(iv && ird == r1))));
            check("rs2_busy", 32'(rs2_busy),
                  32'(r2 != 0 && model_pend[r2] && !(cv && crd == r2 && !(iv && ird == r2))));
            if (cv && crd != 0) e = '{1, crd, cdat};
            else                e = '{0, '0, '0};
            exp_q.push_back(e);
            if (!av && occ > 0) void'(model_fifo.pop_front());
            if (lv && occ < DEPTH) model_fifo.push_back('{rd: lrd, data: ldat});
            if (cv) model_pend[crd] = 0;
            if (iv) model_pend[ird] = 1;
            model_pend[0] = 0;
        end
    endtask

    task automatic idle_cyc(input r_t r1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        // Reset, then settle.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc(0);
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_ready", 32'(lsu_ready), 32'd1);

        // ALU only, with pending[5] set beforehand.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        cyc(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        idle_cyc(5);
        check("x5_cleared", 32'(rs1_busy), 32'd0);

        // LSU results queued behind four ALU commits.
        cyc(1, 1, 1, 32'hA1, 1, 7, 32'h11, 0, 0, 0, 0);
        cyc(1, 1, 2, 32'hA2, 1, 8, 32'h22, 0, 0, 0, 0);
        cyc(1, 1, 3, 32'hA3, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 32'hA4, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle_cyc(0);

        // Fill the FIFO while the ALU hogs the port, then drain.
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 1, 10, 32'(i), 1, r_t'(20 + i), 32'h100 + 32'(i), 0, 0, 0, 0);
        cyc(1, 1, 10, 0, 1, 31, 32'hBAD, 0, 0, 0, 0);
        check("full_ready", 32'(lsu_ready), 32'd0);
        repeat (DEPTH + 2) idle_cyc(0);

        // Scoreboard: issue, commit clears, issue+commit keeps busy.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        idle_cyc(3);
        cyc(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 3, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        cyc(1, 1, 3, 32'h34, 0, 0, 0, 1, 3, 3, 0);
        idle_cyc(3);
        cyc(1, 1, 3, 32'h35, 0, 0, 0, 0, 0, 0, 0);

        // x0 handling.
        cyc(1, 1, 0, 32'h5, 0, 0, 0, 1, 0, 0, 0);
        idle_cyc(0);

        // Reset mid-stream with three queued entries and x4, x9 pending.
        cyc(1, 1, 12, 1, 1, 13, 32'h13, 1, 4, 0, 0);
        cyc(1, 1, 12, 2, 1, 14, 32'h14, 1, 9, 0, 0);
        cyc(1, 1, 12, 3, 1, 15, 32'h15, 0, 0, 4, 9);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc(4);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(lsu_ready), 32'd1);
        repeat (3) idle_cyc(9);

        // Random traffic, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 2) == 0), r_t'($urandom), $urandom,
                ($urandom_range(0, 1) == 0), r_t'($urandom), $urandom,
                ($urandom_range(0, 1) == 0), r_t'($urandom),
                r_t'($urandom), r_t'($urandom));
        end
        repeat (DEPTH + 2) idle_cyc(0);

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
